uart_tx_framed: RTL and testbench

Parametrised UART transmitter with a valid/ready byte handshake and a runtime baud period.
- Data width is set at build time; parity mode and stop-bit count are chosen per frame.
- Back-to-back frames are sent with no idle gap.
- Sits between the stream buffer's read side and the board TX pin, replacing the fixed 8N1 encoder in new designs.

---
 rtl/uart_tx_framed.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_tx_framed.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framed.sv
// UART transmitter with valid/ready byte handshake, runtime bit period,
// per-frame parity mode and one or two stop bits. Frames may be sent
// back to back with no idle gap between stop and next start bit.
//
// Optional build macro UART_TX_BREAK_EN adds an i_Break input that holds
// the line low (break condition) while asserted in IDLE, followed by a
// 2P-clock high mark before the transmitter returns to IDLE.
//
// state      | meaning
// -----------+------------------------------------------------------
// S_IDLE     | line high, waiting for a payload
// S_START    | start bit (low) for P clocks
// S_DATA     | data bits LSB first, P clocks each
// S_PARITY   | parity bit for P clocks (only when parity enabled)
// S_STOP     | stop bit(s), high for P or 2P clocks
// S_BREAK    | line held low while i_Break is asserted (optional)
// S_BRK_HOLD | line high for 2P clocks after a break (optional)
module uart_tx_framed #(
    parameter int DATA_BITS = 8,
    parameter int PERIOD_W  = 20
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic [PERIOD_W-1:0]  i_Period,
    input  logic [1:0]           i_Parity,
    input  logic                 i_Two_Stop,
    input  logic [DATA_BITS-1:0] i_Data,
    input  logic                 i_Valid,
`ifdef UART_TX_BREAK_EN
    input  logic                 i_Break,
`endif
    output logic                 o_Ready,
    output logic                 o_TX,
    output logic                 o_Busy,
    output logic                 o_Done
);

    // Bit counter covers up to 9 data bits and the stop / break-hold halves.
    localparam int BIT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK,
        S_BRK_HOLD
    } state_t;

    state_t               state_q,    state_d;
    logic [PERIOD_W-1:0]  cnt_q,      cnt_d;
    logic [BIT_W-1:0]     bit_q,      bit_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [PERIOD_W-1:0]  period_q,   period_d;
    logic                 par_en_q,   par_en_d;
    logic                 par_bit_q,  par_bit_d;
    logic                 two_stop_q, two_stop_d;
    logic                 tx_q,       tx_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;

    logic                 bit_end;
    logic                 last_stop;
    logic                 accept;
    logic [PERIOD_W-1:0]  period_clamped;

    // Bit timing and handshake decode from the current registered state.
    always_comb begin
        bit_end        = (cnt_q == (period_q - PERIOD_W'(1)));
        last_stop      = (state_q == S_STOP) && bit_end &&
                         (bit_q == BIT_W'(two_stop_q));
        o_Ready        = (state_q == S_IDLE) || last_stop;
        accept         = i_Valid && o_Ready;
        period_clamped = (i_Period < PERIOD_W'(2)) ? PERIOD_W'(2) : i_Period;
    end

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        period_d   = period_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;

        unique case (state_q)
            S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (i_Break) begin
                    state_d  = S_BREAK;
                    period_d = period_clamped;
                    cnt_d    = '0;
                    bit_d    = '0;
                end
`endif
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (last_stop) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                if (!i_Break) begin
                    state_d = S_BRK_HOLD;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_BRK_HOLD: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(1)) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Accept is only possible in IDLE or the final stop clock, so it
        // cleanly overrides whatever the case above chose.
        if (accept) begin
            state_d    = S_START;
            cnt_d      = '0;
            bit_d      = '0;
            shift_d    = i_Data;
            period_d   = period_clamped;
            par_en_d   = (i_Parity != 2'b00);
            two_stop_d = i_Two_Stop;
            unique case (i_Parity)
                2'b01:   par_bit_d = ~(^i_Data);
                2'b10:   par_bit_d = ^i_Data;
                default: par_bit_d = 1'b1;
            endcase
        end

        // Outputs are registered from the next-state values so the line
        // changes exactly on the clock edge that enters each bit.
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_d;
            S_BREAK:  tx_d = 1'b0;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) &&
                 (cnt_d == (period_d - PERIOD_W'(1))) &&
                 (bit_d == BIT_W'(two_stop_d));
    end

    // State and output registers; reset forces the line high at once.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            period_q   <= PERIOD_W'(2);
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            period_q   <= period_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_TX   = tx_q;
    assign o_Busy = busy_q;
    assign o_Done = done_q;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Testbench for uart_tx_framed: directed and random frames compared
// against a per-clock expected line waveform built from the frame format.
module tb_uart_tx_framed;
    localparam int DB = 8;
    localparam int PW = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] period;
    logic [1:0]    parity;
    logic          two_stop;
    logic [DB-1:0] data;
    logic          valid;
    logic          ready, tx, busy, done;
`ifdef UART_TX_BREAK_EN
    logic          brk;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    bit tx_exp_q[$];
    bit done_exp_q[$];

    always #5 clk = ~clk;

    uart_tx_framed #(.DATA_BITS(DB), .PERIOD_W(PW)) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_Period   (period),
        .i_Parity   (parity),
        .i_Two_Stop (two_stop),
        .i_Data     (data),
        .i_Valid    (valid),
`ifdef UART_TX_BREAK_EN
        .i_Break    (brk),
`endif
        .o_Ready    (ready),
        .o_TX       (tx),
        .o_Busy     (busy),
        .o_Done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame model: start 0, data LSB first, optional parity, stop bit(s),
    // each symbol held for the clamped period.
    task automatic push_frame(input logic [DB-1:0] d, input logic [1:0] par,
                              input logic two, input int per);
        int p;
        bit sym[$];
        p = (per < 2) ? 2 : per;
        sym.push_back(1'b0);
        for (int k = 0; k < DB; k++) sym.push_back(d[k]);
        case (par)
            2'b01:   sym.push_back(~(^d));
            2'b10:   sym.push_back(^d);
            2'b11:   sym.push_back(1'b1);
            default: ;
        endcase
        sym.push_back(1'b1);
        if (two) sym.push_back(1'b1);
        foreach (sym[s]) begin
            for (int r = 0; r < p; r++) begin
                tx_exp_q.push_back(sym[s]);
                done_exp_q.push_back(1'b0);
            end
        end
        done_exp_q[done_exp_q.size() - 1] = 1'b1;
    endtask

    // Walk the expected waveform one clock at a time (sampling on negedge),
    // then confirm the line is idle. At index drop_at the payload is
    // withdrawn and all config inputs are scrambled.
    task automatic check_stream(input int drop_at, input string tag);
        for (int i = 0; i < tx_exp_q.size(); i++) begin
            chk($sformatf("%s_tx[%0d]", tag, i), 32'(tx), 32'(tx_exp_q[i]));
            chk($sformatf("%s_done[%0d]", tag, i), 32'(done), 32'(done_exp_q[i]));
            chk($sformatf("%s_ready[%0d]", tag, i), 32'(ready), 32'(done_exp_q[i]));
            chk($sformatf("%s_busy[%0d]", tag, i), 32'(busy), 32'd1);
            if (i == drop_at) begin
                valid    = 1'b0;
                data     = DB'($urandom);
                parity   = 2'($urandom_range(0, 3));
                two_stop = 1'($urandom_range(0, 1));
                period   = PW'($urandom_range(0, 7));
            end
            @(negedge clk);
        end
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_tx"}, 32'(tx), 32'd1);
        chk({tag, "_idle_ready"}, 32'(ready), 32'd1);
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
    endtask

    task automatic start_frame(input logic [DB-1:0] d, input logic [1:0] par,
                               input logic two, input int per, input string tag);
        data     = d;
        parity   = par;
        two_stop = two;
        period   = PW'(per);
        valid    = 1'b1;
        chk({tag, "_ready_pre"}, 32'(ready), 32'd1);
        tx_exp_q.delete();
        done_exp_q.delete();
        push_frame(d, par, two, per);
        @(negedge clk);
        check_stream(0, tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        valid    = 1'b0;
        data     = '0;
        parity   = 2'b00;
        two_stop = 1'b0;
        period   = PW'(4);
`ifdef UART_TX_BREAK_EN
        brk      = 1'b0;
`endif
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1, P=4, 0xA5
        start_frame(8'hA5, 2'b00, 1'b0, 4, "t1");

        // parity modes at P=3 on 0x07
        start_frame(8'h07, 2'b10, 1'b0, 3, "t2_even");
        start_frame(8'h07, 2'b01, 1'b0, 3, "t2_odd");
        start_frame(8'h07, 2'b11, 1'b0, 3, "t2_mark");

        // two stop bits, P=5
        start_frame(8'h00, 2'b00, 1'b1, 5, "t3");

        // back-to-back with valid held high; data changes mid-frame
        data     = 8'h55;
        parity   = 2'b00;
        two_stop = 1'b0;
        period   = PW'(2);
        valid    = 1'b1;
        chk("t4_ready_pre", 32'(ready), 32'd1);
        tx_exp_q.delete();
        done_exp_q.delete();
        push_frame(8'h55, 2'b00, 1'b0, 2);
        push_frame(8'h0F, 2'b00, 1'b0, 2);
        @(negedge clk);
        data = 8'h0F;
        check_stream(20, "t4");

        // period clamp
        start_frame(8'hC3, 2'b00, 1'b0, 0, "t5_p0");
        start_frame(8'h5A, 2'b10, 1'b1, 1, "t5_p1");

        // reset mid-frame
        data     = 8'h3C;
        parity   = 2'b00;
        two_stop = 1'b0;
        period   = PW'(2);
        valid    = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("t5_rst_pre_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", 32'(tx), 32'd1);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ready", 32'(ready), 32'd1);
        chk("t5_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_post_ready", 32'(ready), 32'd1);
        start_frame(8'h96, 2'b01, 1'b0, 3, "t5_after");

        // random frames
        for (int f = 0; f < 6; f++) begin
            start_frame(DB'($urandom), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                        $sformatf("rnd%0d", f));
        end

`ifdef UART_TX_BREAK_EN
        // break in IDLE for 20 clocks, then 2P high, then ready
        period = PW'(4);
        brk    = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk($sformatf("t6_brk_tx[%0d]", j), 32'(tx), 32'd0);
            chk($sformatf("t6_brk_busy[%0d]", j), 32'(busy), 32'd1);
            chk($sformatf("t6_brk_ready[%0d]", j), 32'(ready), 32'd0);
            if (j == 19) brk = 1'b0;
        end
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk($sformatf("t6_hold_tx[%0d]", j), 32'(tx), 32'd1);
            chk($sformatf("t6_hold_ready[%0d]", j), 32'(ready), 32'd0);
        end
        @(negedge clk);
        chk("t6_end_ready", 32'(ready), 32'd1);
        chk("t6_end_busy", 32'(busy), 32'd0);

        // break raised mid-frame is deferred
        data     = 8'hE1;
        parity   = 2'b10;
        two_stop = 1'b0;
        period   = PW'(4);
        valid    = 1'b1;
        chk("t6m_ready_pre", 32'(ready), 32'd1);
        tx_exp_q.delete();
        done_exp_q.delete();
        push_frame(8'hE1, 2'b10, 1'b0, 4);
        @(negedge clk);
        brk = 1'b1;
        check_stream(0, "t6m");
        period = PW'(4);
        @(negedge clk);
        chk("t6m_brk_tx", 32'(tx), 32'd0);
        chk("t6m_brk_busy", 32'(busy), 32'd1);
        brk = 1'b0;
        repeat (9) @(negedge clk);
        chk("t6m_end_ready", 32'(ready), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
